// File: rtl/addsub_accum_if.sv
// Request/result bundle for the add/sub accumulator.
// The requester drives in_valid/Op/B and the accumulator drives everything else.
interface addsub_accum_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] Op;
   logic [3:0] B;
   logic [3:0] Acc;
   logic       Co;
   logic       V;
   logic       Z;
   logic       out_valid;

   modport master (
      output in_valid, Op, B,
      input  in_ready, Acc, Co, V, Z, out_valid
   );

   modport slave (
      input  in_valid, Op, B,
      output in_ready, Acc, Co, V, Z, out_valid
   );
endinterface

// File: rtl/addsub_accum.sv
// 4-bit two's complement accumulator with ADD/SUB/LOAD/CLEAR and optional saturation.
// Each accepted request takes IDLE -> EXEC -> DONE; the result lands on the edge that ends EXEC.
//
// state | meaning
// IDLE  | ready, waiting for in_valid
// EXEC  | operands captured, adder settling from Acc
// DONE  | new Acc/Co/V visible, out_valid high
module addsub_accum #(
   parameter bit SAT = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   addsub_accum_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;

   state_t     state, state_nxt;
   logic       accept;
   logic       in_ready;
   logic       out_valid;

   logic [1:0] op_q;
   logic [3:0] b_q;
   logic [3:0] acc_q;
   logic       co_q;
   logic       v_q;

   logic [3:0] eff_b;
   logic [4:0] carry;
   logic [3:0] sum;
   logic       ovf;
   logic [3:0] acc_nxt;
   logic       co_nxt;
   logic       v_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are frozen at acceptance so the requester may change them freely afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= 2'b00;
         b_q  <= 4'h0;
      end else if (accept) begin
         op_q <= bus.Op;
         b_q  <= bus.B;
      end
   end

   // Ripple adder: SUB is A + ~B + 1, so Co = 1 means no borrow.
   always_comb begin
      eff_b    = (op_q == OP_SUB) ? ~b_q : b_q;
      carry    = '0;
      sum      = '0;
      carry[0] = (op_q == OP_SUB);
      for (int i = 0; i < 4; i++) begin
         sum[i]     = acc_q[i] ^ eff_b[i] ^ carry[i];
         carry[i+1] = (acc_q[i] & eff_b[i]) | (carry[i] & (acc_q[i] ^ eff_b[i]));
      end
      ovf = (acc_q[3] == eff_b[3]) & (sum[3] != acc_q[3]);
   end

   always_comb begin
      acc_nxt = 4'h0;
      co_nxt  = 1'b0;
      v_nxt   = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            co_nxt = carry[4];
            v_nxt  = ovf;
            if (SAT && ovf) begin
               acc_nxt = acc_q[3] ? 4'b1000 : 4'b0111;
            end else begin
               acc_nxt = sum;
            end
         end
         OP_LOAD: acc_nxt = b_q;
         default: acc_nxt = 4'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 4'h0;
         co_q  <= 1'b0;
         v_q   <= 1'b0;
      end else if (state == EXEC) begin
         acc_q <= acc_nxt;
         co_q  <= co_nxt;
         v_q   <= v_nxt;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.Acc       = acc_q;
   assign bus.Co        = co_q;
   assign bus.V         = v_q;
   assign bus.Z         = (acc_q == 4'h0);

endmodule

// File: tb/tb_addsub_accum.sv
// Drives a wrapping and a saturating accumulator with identical requests and
// checks both against an integer-arithmetic model of the accumulator rules.
module tb_addsub_accum;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   addsub_accum_if if0 ();
   addsub_accum_if if1 ();

   addsub_accum #(.SAT(1'b0)) dut_wrap (.clk(clk), .rst(rst), .bus(if0));
   addsub_accum #(.SAT(1'b1)) dut_sat  (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   logic [3:0] m_acc [2];
   logic       m_co  [2];
   logic       m_v   [2];

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [1:0] op, input logic [3:0] b);
      if0.in_valid = vld;  if1.in_valid = vld;
      if0.Op       = op;   if1.Op       = op;
      if0.B        = b;    if1.B        = b;
   endtask

   function automatic int to_s(input logic [3:0] x);
      return x[3] ? int'(x) - 16 : int'(x);
   endfunction

   // Reference: plain signed/unsigned arithmetic, one model per SAT setting.
   task automatic model_apply(input logic [1:0] op, input logic [3:0] b);
      for (int d = 0; d < 2; d++) begin
         int ua, ub, ures, sres;
         logic ov;
         ua = int'(m_acc[d]);
         ub = int'(b);
         case (op)
            2'b00, 2'b01: begin
               if (op == 2'b00) begin
                  ures     = ua + ub;
                  m_co[d]  = (ures > 15);
                  sres     = to_s(m_acc[d]) + to_s(b);
               end else begin
                  ures     = ua - ub + 16;
                  m_co[d]  = (ua >= ub);
                  sres     = to_s(m_acc[d]) - to_s(b);
               end
               ov      = (sres > 7) || (sres < -8);
               m_v[d]  = ov;
               if (d == 1 && ov)
                  m_acc[d] = (to_s(m_acc[d]) >= 0) ? 4'd7 : 4'd8;
               else
                  m_acc[d] = 4'(ures % 16);
            end
            2'b10: begin m_acc[d] = b;    m_co[d] = 1'b0; m_v[d] = 1'b0; end
            default: begin m_acc[d] = 4'h0; m_co[d] = 1'b0; m_v[d] = 1'b0; end
         endcase
      end
   endtask

   task automatic chk_results(input string tag);
      chk({tag, "_acc0"}, if0.Acc, m_acc[0]);
      chk({tag, "_co0"},  {3'b0, if0.Co}, {3'b0, m_co[0]});
      chk({tag, "_v0"},   {3'b0, if0.V},  {3'b0, m_v[0]});
      chk({tag, "_z0"},   {3'b0, if0.Z},  {3'b0, (m_acc[0] == 4'h0)});
      chk({tag, "_acc1"}, if1.Acc, m_acc[1]);
      chk({tag, "_co1"},  {3'b0, if1.Co}, {3'b0, m_co[1]});
      chk({tag, "_v1"},   {3'b0, if1.V},  {3'b0, m_v[1]});
   endtask

   // Called at posedge+1 with the DUTs in IDLE; returns at posedge+1 back in IDLE.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] b);
      chk({tag, "_rdy_idle"}, {3'b0, if0.in_ready}, 4'd1);
      drive(1'b1, op, b);
      @(posedge clk); #1;
      drive(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      model_apply(op, b);
      chk({tag, "_rdy_exec"}, {3'b0, if0.in_ready}, 4'd0);
      chk({tag, "_ov_exec"},  {3'b0, if0.out_valid, if1.out_valid}, 4'd0);
      @(posedge clk); #1;
      chk({tag, "_ov_done"},  {3'b0, if0.out_valid, if1.out_valid}, 4'd3);
      chk({tag, "_rdy_done"}, {3'b0, if1.in_ready}, 4'd0);
      chk_results(tag);
      @(posedge clk); #1;
      chk({tag, "_ov_idle"},  {3'b0, if0.out_valid, if1.out_valid}, 4'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = 4'h0; m_co[d] = 1'b0; m_v[d] = 1'b0;
      end
      drive(1'b0, 2'b00, 4'h0);
      #2;
      chk("rst_acc",   if0.Acc, 4'h0);
      chk("rst_flags", {if0.Co, if0.V, if0.out_valid, if0.Z}, 4'b0001);
      chk("rst_ready", {3'b0, if0.in_ready}, 4'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("add3", 2'b00, 4'd3);
      chk("add3_val", if0.Acc, 4'd3);
      run_op("add4", 2'b00, 4'd4);
      chk("add4_val", if0.Acc, 4'd7);

      run_op("ld7",  2'b10, 4'd7);
      run_op("ovf",  2'b00, 4'd1);
      chk("ovf_wrap", if0.Acc, 4'b1000);
      chk("ovf_sat",  if1.Acc, 4'b0111);

      run_op("ld5",  2'b10, 4'd5);
      run_op("sub5", 2'b01, 4'd5);
      chk("sub5_zco", {2'b0, if0.Z, if0.Co}, 4'b0011);
      run_op("ld0",  2'b10, 4'd0);
      run_op("sub1", 2'b01, 4'd1);
      chk("sub1_val", if0.Acc, 4'b1111);

      run_op("ld8",  2'b10, 4'b1000);
      run_op("nsub", 2'b01, 4'd1);
      chk("nsub_sat", {if1.Acc}, 4'b1000);
      chk("nsub_v",   {3'b0, if1.V}, 4'd1);
      run_op("clr",  2'b11, 4'd9);
      chk("clr_z", {3'b0, if1.Z}, 4'd1);

      // Continuous in_valid: only IDLE cycles accept, one every third cycle.
      for (int k = 0; k < 9; k++) begin
         logic [3:0] bk;
         bk = 4'($urandom_range(0, 15));
         chk("hold_rdy", {3'b0, if0.in_ready}, {3'b0, ((k % 3) == 0)});
         if ((k % 3) == 0) model_apply(2'b00, bk);
         if ((k % 3) == 2) begin
            chk("hold_ov", {3'b0, if0.out_valid}, 4'd1);
            chk_results("hold");
         end
         drive(1'b1, 2'b00, bk);
         @(posedge clk); #1;
      end
      drive(1'b0, 2'b00, 4'h0);

      for (int n = 0; n < 40; n++) begin
         run_op("rnd", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end

      // Reset mid-EXEC aborts the operation.
      run_op("ld6", 2'b10, 4'd6);
      drive(1'b1, 2'b00, 4'd1);
      @(posedge clk); #1;
      drive(1'b0, 2'b00, 4'h0);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = 4'h0; m_co[d] = 1'b0; m_v[d] = 1'b0;
      end
      chk("abort_acc",   if0.Acc, 4'h0);
      chk("abort_ready", {3'b0, if0.in_ready}, 4'd1);
      chk("abort_ov",    {3'b0, if0.out_valid}, 4'd0);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("abort_no_ov", {3'b0, if0.out_valid, if1.out_valid}, 4'd0);
         chk("abort_hold",  if1.Acc, 4'h0);
      end
      run_op("add2", 2'b00, 4'd2);
      chk("add2_val", if0.Acc, 4'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
